// File: rtl/radar_pkg.sv
// radar_pkg: shared definitions for the radar front-end.
//   N_RADAR        number of raw radar lines
//   DEF_*          default timing constants and counter width
//   track_state_e  lock-on FSM state encoding
//   popcount / lowest_bit  helpers over a detection vector
package radar_pkg;

  localparam int unsigned N_RADAR         = 3;
  localparam int unsigned DEF_DEB_CYCLES  = 16;
  localparam int unsigned DEF_LOCK_CYCLES = 8;
  localparam int unsigned DEF_HOLD_CYCLES = 4;
  localparam int unsigned DEF_CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HOLD    = 2'd3
  } track_state_e;

  function automatic int unsigned popcount(input logic [N_RADAR-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < N_RADAR; i++) cnt = cnt + 32'(v[i]);
    return cnt;
  endfunction

  // Keeps only the lowest-index set bit (e.g. 110 -> 010).
  function automatic logic [N_RADAR-1:0] lowest_bit(input logic [N_RADAR-1:0] v);
    logic [N_RADAR-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < N_RADAR; i++) begin
      if (v[i] && (res == '0)) res[i] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/radar_debounce.sv
// radar_debounce: one radar channel, 2-FF synchroniser plus debounce counter.
// The clean output flips only after the synced line has differed from it for
// DEB_CYCLES consecutive cycles.
// Ports:
//   clock    system clock (rising edge)
//   reset_n  synchronous active-low reset
//   raw      asynchronous raw radar line
//   clean    debounced level
module radar_debounce
  import radar_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic clean
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      clean  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 != clean) begin
        if (cnt == DEB_LAST) begin
          clean <= sync_2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/radar_tracker.sv
// radar_tracker: conditions three raw radar lines and runs a lock-on FSM,
// producing a clean one-hot track vector for the control core.
// Ports:
//   clock       system clock (rising edge)
//   reset_n     synchronous active-low reset
//   radar_raw   raw asynchronous radar lines, bit0 = radar 1
//   track       registered one-hot locked target, 000 = none
//   lock_pulse  one-cycle pulse on ACQUIRE -> LOCKED
//   lost_pulse  one-cycle pulse on HOLD -> IDLE timeout
//   conflict    registered, 1 while more than one debounced line is active
// Build option RADAR_PRIORITY_EN: in IDLE/ACQUIRE the detection vector is
// priority-resolved (lowest index wins) so overlapping detections can still
// be acquired; conflict keeps reporting the unresolved vector.
module radar_tracker
  import radar_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_RADAR-1:0] radar_raw,
  output logic [N_RADAR-1:0] track,
  output logic               lock_pulse,
  output logic               lost_pulse,
  output logic               conflict
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [N_RADAR-1:0] det;
  logic [N_RADAR-1:0] det_acq;

  track_state_e       state_q, state_d;
  logic [N_RADAR-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [N_RADAR-1:0] track_d;
  logic               lock_d, lost_d, conflict_d;

  for (genvar g = 0; g < N_RADAR; g++) begin : g_ch
    radar_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (radar_raw[g]),
      .clean  (det[g])
    );
  end

  always_comb begin
`ifdef RADAR_PRIORITY_EN
    det_acq = lowest_bit(det);
`else
    det_acq = det;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    timer_d    = timer_q;
    track_d    = track;
    lock_d     = 1'b0;
    lost_d     = 1'b0;
    conflict_d = (popcount(det) > 1);
    case (state_q)
      IDLE: begin
        track_d = '0;
        if (popcount(det_acq) == 1) begin
          cand_d  = det_acq;
          timer_d = '0;
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (det_acq != cand_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == LOCK_LAST) begin
          state_d = LOCKED;
          track_d = cand_q;
          lock_d  = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        track_d = cand_q;
        if (det != cand_q) begin
          state_d = HOLD;
          timer_d = '0;
        end
      end
      HOLD: begin
        // Only the held candidate can revive the lock; any other target
        // has to wait for IDLE.
        if (det == cand_q) begin
          state_d = LOCKED;
        end else if (timer_q == HOLD_LAST) begin
          state_d = IDLE;
          track_d = '0;
          timer_d = '0;
          lost_d  = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      timer_q    <= '0;
      track      <= '0;
      lock_pulse <= 1'b0;
      lost_pulse <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      timer_q    <= timer_d;
      track      <= track_d;
      lock_pulse <= lock_d;
      lost_pulse <= lost_d;
      conflict   <= conflict_d;
    end
  end

endmodule

// File: tb/tb_radar_tracker.sv
// tb_radar_tracker: directed bench for radar_tracker with
// DEB_CYCLES=4, LOCK_CYCLES=3, HOLD_CYCLES=2. A second instance with a longer
// hold window exercises recovery from HOLD, since with HOLD_CYCLES=2 a
// debounced dropout (>= 4 cycles) always outlasts the hold window.
module tb_radar_tracker;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] radar_raw;
  logic [2:0] track;
  logic       lock_pulse, lost_pulse, conflict;

  logic [2:0] raw_b;
  logic [2:0] track_b;
  logic       lock_b, lost_b, conflict_b;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clock = ~clock;

  radar_tracker #(
    .DEB_CYCLES (4),
    .LOCK_CYCLES(3),
    .HOLD_CYCLES(2),
    .CNT_W      (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .radar_raw (radar_raw),
    .track     (track),
    .lock_pulse(lock_pulse),
    .lost_pulse(lost_pulse),
    .conflict  (conflict)
  );

  radar_tracker #(
    .DEB_CYCLES (4),
    .LOCK_CYCLES(3),
    .HOLD_CYCLES(8),
    .CNT_W      (8)
  ) dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .radar_raw (raw_b),
    .track     (track_b),
    .lock_pulse(lock_b),
    .lost_pulse(lost_b),
    .conflict  (conflict_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns later.
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // From IDLE with clean=000: clean flips at edge 6, ACQUIRE at 7, LOCKED at 10.
  task automatic lock_on(input logic [2:0] v, input string tag);
    radar_raw = v;
    step(9);
    check({tag, "_prelock_track"}, 32'(track), 32'(3'b000));
    check({tag, "_prelock_pulse"}, 32'(lock_pulse), 32'(0));
    step(1);
    check({tag, "_lock_track"}, 32'(track), 32'(v));
    check({tag, "_lock_pulse"}, 32'(lock_pulse), 32'(1));
    step(1);
    check({tag, "_lock_pulse_end"}, 32'(lock_pulse), 32'(0));
    check({tag, "_locked_track"}, 32'(track), 32'(v));
  endtask

  // Clean drops at edge 6, HOLD at 7 and 8, IDLE with lost_pulse at 9.
  task automatic lose(input logic [2:0] v, input string tag);
    radar_raw = 3'b000;
    step(8);
    check({tag, "_hold_track"}, 32'(track), 32'(v));
    check({tag, "_hold_nolost"}, 32'(lost_pulse), 32'(0));
    step(1);
    check({tag, "_lost_track"}, 32'(track), 32'(3'b000));
    check({tag, "_lost_pulse"}, 32'(lost_pulse), 32'(1));
    step(1);
    check({tag, "_lost_pulse_end"}, 32'(lost_pulse), 32'(0));
  endtask

  initial begin
    logic seen;
    logic bad_track, any_lost, any_lock;

    reset_n   = 1'b0;
    radar_raw = 3'b000;
    raw_b     = 3'b000;
    step(3);
    check("rst_track", 32'(track), 32'(3'b000));
    check("rst_lock", 32'(lock_pulse), 32'(0));
    check("rst_lost", 32'(lost_pulse), 32'(0));
    check("rst_conflict", 32'(conflict), 32'(0));

    // 3-cycle glitch is shorter than the debounce window.
    reset_n   = 1'b1;
    radar_raw = 3'b001;
    seen      = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 3) radar_raw = 3'b000;
      step(1);
      seen = seen | (|track) | lock_pulse | lost_pulse | conflict;
    end
    check("glitch_reject", 32'(seen), 32'(0));

    lock_on(3'b010, "lock010");
    lose(3'b010, "loss010");
    lock_on(3'b100, "lock100");
    lose(3'b100, "loss100");

    // Overlapping detections from IDLE.
    radar_raw = 3'b011;
    step(7);
    check("conf_flag", 32'(conflict), 32'(1));
    check("conf_track_early", 32'(track), 32'(3'b000));
    step(3);
`ifdef RADAR_PRIORITY_EN
    check("conf_track", 32'(track), 32'(3'b001));
    check("conf_lock", 32'(lock_pulse), 32'(1));
`else
    check("conf_track", 32'(track), 32'(3'b000));
    check("conf_lock", 32'(lock_pulse), 32'(0));
`endif
    check("conf_flag_held", 32'(conflict), 32'(1));
    radar_raw = 3'b000;
    step(20);
    check("conf_clear", 32'(conflict), 32'(0));
    check("conf_idle_track", 32'(track), 32'(3'b000));

    // Reset while locked: track drops at once, no lost_pulse, then relock.
    lock_on(3'b100, "pre_rst");
    reset_n = 1'b0;
    step(1);
    check("midrst_track", 32'(track), 32'(3'b000));
    check("midrst_lost", 32'(lost_pulse), 32'(0));
    check("midrst_lock", 32'(lock_pulse), 32'(0));
    reset_n = 1'b1;
    step(9);
    check("relock_pre", 32'(track), 32'(3'b000));
    step(1);
    check("relock_track", 32'(track), 32'(3'b100));
    check("relock_pulse", 32'(lock_pulse), 32'(1));

    // Hold recovery on the long-hold instance: a 4-cycle raw dropout.
    raw_b = 3'b010;
    step(10);
    check("b_lock_track", 32'(track_b), 32'(3'b010));
    check("b_lock_pulse", 32'(lock_b), 32'(1));
    step(1);
    raw_b     = 3'b000;
    bad_track = 1'b0;
    any_lost  = 1'b0;
    any_lock  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) raw_b = 3'b010;
      step(1);
      bad_track = bad_track | (track_b != 3'b010);
      any_lost  = any_lost | lost_b;
      any_lock  = any_lock | lock_b;
    end
    check("b_hold_track", 32'(bad_track), 32'(0));
    check("b_hold_nolost", 32'(any_lost), 32'(0));
    check("b_hold_nolock", 32'(any_lock), 32'(0));
    check("b_conflict", 32'(conflict_b), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
